// File: rtl/demux_credit_sched_pkg.sv
// demux_credit_sched_pkg: shared state encoding and default sizing for the demux credit scheduler.
package demux_credit_sched_pkg;
    typedef enum logic [1:0] {INIT, RUN, FLUSH} state_t;
    localparam int CREDITS_DEFAULT = 4;
    localparam int DATA_W_DEFAULT = 4;
endpackage

// File: rtl/demux_credit_sched_credit_counter.sv
// credit_counter: per-port downstream credit count with saturating return and sticky overflow.
module credit_counter
    import demux_credit_sched_pkg::*;
#(
    parameter int CREDITS = CREDITS_DEFAULT,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             overflow
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= FULL;
            overflow <= 1'b0;
        end else if (inc && !dec) begin
            if (count == FULL) overflow <= 1'b1;
            else count <= count + 1'b1;
        end else if (dec && !inc) begin
            count <= count - 1'b1;
        end
    end

    assign nonzero = count != '0;
endmodule

// File: rtl/demux_credit_sched.sv
// demux_credit_sched: credit-aware port scheduler driving registered select/valid/data into a 1:2 demux.
module demux_credit_sched
    import demux_credit_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CREDITS = CREDITS_DEFAULT,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_out,
    input  logic              mode,
    input  logic              flush,
    input  logic              credit_ret0,
    input  logic              credit_ret1,
    output logic              selector,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  credits0,
    output logic [CNT_W-1:0]  credits1,
    output logic              busy,
    output logic              err
);
    state_t state;
    logic last, pick, avail, accept, nz0, nz1, ovf0, ovf1;

    // Round-robin prefers !last and falls back to last; steering follows the data MSB.
    always_comb begin
        pick = mode ? data_in[DATA_W-1] : ((last ? nz0 : nz1) ? !last : last);
        avail = mode ? (pick ? nz1 : nz0) : (nz0 | nz1);
    end

    assign ready_out = (state == RUN) && avail;
    assign accept = valid_in && ready_out;
    assign busy = state != RUN;
    assign err = ovf0 | ovf1;

    credit_counter #(.CREDITS(CREDITS), .CNT_W(CNT_W)) u_cc0 (
        .clk(clk), .reset(reset), .dec(accept && !pick), .inc(credit_ret0),
        .count(credits0), .nonzero(nz0), .overflow(ovf0)
    );

    credit_counter #(.CREDITS(CREDITS), .CNT_W(CNT_W)) u_cc1 (
        .clk(clk), .reset(reset), .dec(accept && pick), .inc(credit_ret1),
        .count(credits1), .nonzero(nz1), .overflow(ovf1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
            last <= 1'b1;
            selector <= 1'b0;
            valid_out <= 1'b0;
            data_out <= '0;
        end else begin
            valid_out <= accept;
            if (accept) begin
                selector <= pick;
                data_out <= data_in;
                last <= pick;
            end
            case (state)
                INIT: state <= RUN;
                RUN: if (flush) state <= FLUSH;
                FLUSH: if (!flush && credits0 == CNT_W'(CREDITS) && credits1 == CNT_W'(CREDITS)) state <= RUN;
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: doc/demux_credit_sched.md
Name: demux_credit_sched

Overview:
Scheduler that feeds the 1:2 four-bit demux (selector/valid/data_in) from a single upstream valid/ready stream.
- Chooses the demux output port per word: round-robin or destination-bit steering.
- Tracks per-port credits so no downstream buffer overflows.
- Registers the demux control, giving the demux a clean, glitch-free selector and valid.
- Sits between the upstream word source and the demux in the L2 distribution path.

Parameters:
DATA_W, 4, width of data word passed to the demux
CREDITS, 4, downstream buffer depth per port; initial and maximum credit value
CNT_W, 3, credit counter width; must hold CREDITS

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
valid_in  input  1  upstream word valid
data_in  input  DATA_W  upstream word
ready_out  output  1  upstream may transfer this cycle (valid_in && ready_out = accept)
mode  input  1  0 = round-robin, 1 = destination steering by data_in[DATA_W-1]
flush  input  1  level request: stop accepting until both ports are fully credited
credit_ret0  input  1  downstream port 0 consumed one word
credit_ret1  input  1  downstream port 1 consumed one word
selector  output  1  demux select (1 = port 1)
valid_out  output  1  demux valid
data_out  output  DATA_W  demux data
credits0  output  CNT_W  current port 0 credit count
credits1  output  CNT_W  current port 1 credit count
busy  output  1  high in INIT or FLUSH
err  output  1  sticky: credit returned while counter already at CREDITS

Behaviour:
Reset (async assert, sync release):
- selector=0, valid_out=0, data_out=0, credits0=credits1=CREDITS, err=0, RR pointer last=1 (so port 0 is served first), state=INIT.

States:
- INIT: one cycle after reset release; ready_out=0, busy=1 -> RUN.
- RUN: normal operation; ready_out per the rules below.
  - -> FLUSH when flush=1. Takes effect the next cycle; the current cycle's accept still completes.
- FLUSH: ready_out=0, busy=1.
  - -> RUN when flush=0 and credits0==CREDITS and credits1==CREDITS.

Port choice, round-robin (mode=0):
- Preferred port = !last. If its credit is >0, use it; else use last if its credit is >0.
- Neither has credit -> ready_out=0.
- last updates only on accept.

Port choice, steering (mode=1):
- Port = data_in[DATA_W-1]; ready_out = (credit[port]>0).
- ready_out may depend combinationally on data_in and mode; it must not depend on valid_in.

Accept (valid_in && ready_out in RUN):
- Next cycle: valid_out=1, selector=chosen port, data_out=data_in.
- Latency is exactly 1 cycle.
- Chosen port's credit is decremented.

No accept:
- valid_out=0 next cycle.
- selector and data_out hold their previous values (demux holds its last outputs).

Credits:
- Per port, same cycle: decrement on accept to that port, increment on credit_retN.
- Both in the same cycle -> unchanged.
- Increment at CREDITS saturates and sets err. err clears only on reset.
- Credit 0 with a simultaneous return: the return is visible to ready_out only the following cycle (ready uses registered counts).

mode change: takes effect the same cycle. last is not reset.

flush: asserted with no traffic and full credits -> FLUSH for one cycle, then RUN once flush drops.

Reset mid-operation: all state returns to reset values immediately; an in-flight valid_out is dropped.

Decomposition:
- Shared package: state encoding (INIT, RUN, FLUSH); constants CREDITS_DEFAULT=4, DATA_W_DEFAULT=4.
- Natural sub-module: credit_counter (one per port). Inputs clk, reset, dec, inc. Outputs count, nonzero, overflow.
- Port choice and FSM stay in the top module.

Test Plan:
- Reset, then 4 words (0x1,0x2,0x3,0x4) valid every cycle, mode=0, no returns.
  - Required: ready_out=0 in the INIT cycle.
  - Then selector sequence 0,1,0,1, each one cycle after accept; credits end at 2/2.
- mode=0, no returns, 9 consecutive valid words.
  - Required: 8 accepted.
  - ready_out=0 once both credits are 0; valid_out=0 next cycle with selector/data held.
  - credit_ret1 pulse -> next cycle one word accepted to port 1.
- mode=1, words 0x9,0xA,0xB,0xC,0xD (bit3=1).
  - Required: 4 accepted to port 1; fifth stalls with credits1=0.
  - Word 0x2 presented meanwhile -> accepted to port 0.
- Same-cycle accept to port 0 and credit_ret0 with credits0=2.
  - Required: credits0 stays 2.
  - Extra credit_ret0 at credits0=4 -> stays 4, err=1 and sticky.
- Two words to port 0, then flush=1 for 1 cycle, then credit_ret0 twice, 3 cycles apart.
  - Required: busy=1 and ready_out=0 until credits0 returns to 4, then RUN.
- reset asserted while valid_out=1, asynchronously mid-cycle.
  - Required: valid_out, data_out, selector immediately 0; credits 4/4; INIT on release.
